regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
- Parametrised successor to the RV32I 32x32 dual-read/single-write register file.
- Configurable width, depth, read-port count and write-port count.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard (reserve at issue, clear at writeback).
- Sits between decode/issue and writeback in the pipeline core, and serves as the base for a future dual-issue core.

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, number of registers (power of two, >=2); AW = $clog2(NUM_REGS) is a derived localparam
NUM_READ, 2, number of read ports (>=1)
NUM_WRITE, 1, number of write ports (>=1)
ZERO_REG, 1, 1 = register 0 hardwired to zero (reads 0, writes/reserves ignored)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
read_addr  in  NUM_READ*AW  read addresses, port p at bits [p*AW +: AW]
read_data  out  NUM_READ*XLEN  read data, port p at bits [p*XLEN +: XLEN]
read_busy  out  NUM_READ  scoreboard busy flag of each read port's register
write_enable  in  NUM_WRITE  per-port write enable
write_addr  in  NUM_WRITE*AW  write addresses
write_data  in  NUM_WRITE*XLEN  write data
reserve_enable  in  1  mark reserve_addr busy (pending writeback)
reserve_addr  in  AW  destination register to reserve
busy_vector  out  NUM_REGS  registered scoreboard, bit r = register r busy

Behaviour:
- Reset: on reset_n low, immediately and asynchronously clear all registers to 0 and all busy bits to 0. read_data then shows 0 (combinational from the cleared array). read_busy = 0, busy_vector = 0. Reset mid-operation discards pending writes and reservations.
- Reads: combinational, zero latency.
  - ZERO_REG=1 and address 0 -> read_data 0, read_busy 0, regardless of bypass.
- Writes: commit on rising clock edge when write_enable[w]=1.
  - ZERO_REG=1 and address 0 -> ignored, no busy change.
  - Several write ports to the same address in one cycle: highest-indexed port wins, for both storage and bypass.
- Bypass (BYPASS=1): if any enabled write port in the current cycle targets read_addr[p] (non-zero when ZERO_REG), read_data[p] = that port's write_data (highest index wins). Otherwise it is the stored value.
- Busy set: reserve_enable=1 sets busy[reserve_addr] at the clock edge. Ignored for address 0 when ZERO_REG.
- Busy clear: any enabled write to register r clears busy[r] at the edge.
- Simultaneous reserve and write to the same r: the reserve wins, so busy[r]=1 after the edge. A new producer has been issued behind the retiring one.
- read_busy[p]:
  - BYPASS=1: busy[read_addr[p]] AND NOT (a same-cycle enabled write to that address).
  - BYPASS=0: the raw registered busy bit.
- busy_vector is always the raw registered state, with no bypass.
- Reserve of an already-busy register: stays busy; no counting of outstanding writes.
- Write to a non-busy register: legal; data is stored and busy stays 0.
- Address width is exact (NUM_REGS is a power of two), so there are no out-of-range addresses.
- Write storage is on the clock; reset is asynchronous. No other state exists.

Test Plan:
- Reset: write 0xDEADBEEF to x5, then pulse reset_n low mid-cycle -> read_data for x5 = 0 immediately; busy_vector = 0.
- Basic R/W (defaults): write x7=0x12345678; next cycle read ports 0/1 at x7/x0 -> 0x12345678 / 0x00000000. Write x0=0xFFFFFFFF -> x0 still reads 0.
- Bypass: same cycle write x3=0xA5A5A5A5, read port1 addr x3 -> 0xA5A5A5A5 combinationally. Rebuild with BYPASS=0 -> old value of x3 (0) that cycle, 0xA5A5A5A5 next cycle.
- Scoreboard: reserve x9 -> busy_vector[9]=1 and read_busy=1 next cycle. Write x9=0x55 -> read_busy=0 in the write cycle (bypass); busy_vector[9]=0 after the edge.
- Reserve/write collision: busy[4]=1; same cycle write x4=0x1 and reserve x4 -> after the edge busy[4]=1 and x4 reads 0x1.
- NUM_WRITE=2, NUM_READ=4, XLEN=64: both write ports target x10 with 0x1111 (port0) and 0x2222 (port1) -> all read ports at x10 see 0x2222, stored 0x2222. Distinct addresses x11/x12 written in the same cycle both persist.

Source files
------------

// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised multi-port register file with write-to-read bypass and busy scoreboard
module regfile_multiport #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  parameter int NUM_WRITE = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_READ*AW-1:0]    read_addr,
  output logic [NUM_READ*XLEN-1:0]  read_data,
  output logic [NUM_READ-1:0]       read_busy,
  input  logic [NUM_WRITE-1:0]      write_enable,
  input  logic [NUM_WRITE*AW-1:0]   write_addr,
  input  logic [NUM_WRITE*XLEN-1:0] write_data,
  input  logic                      reserve_enable,
  input  logic [AW-1:0]             reserve_addr,
  output logic [NUM_REGS-1:0]       busy_vector
);
  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_WRITE-1:0] wv;

  for (genvar w = 0; w < NUM_WRITE; w++) begin : g_wv
    assign wv[w] = write_enable[w] && !(ZERO_REG && write_addr[w*AW +: AW] == '0);
  end

  // Later ports overwrite earlier ones, so the highest index wins; reserve is applied last so it beats a clear
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wv[w]) begin
        regs_d[write_addr[w*AW +: AW]] = write_data[w*XLEN +: XLEN];
        busy_d[write_addr[w*AW +: AW]] = 1'b0;
      end
    end
    if (reserve_enable && !(ZERO_REG && reserve_addr == '0)) busy_d[reserve_addr] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic [XLEN-1:0] bd;
    logic hit, zr;
    assign ra = read_addr[p*AW +: AW];
    assign zr = ZERO_REG && ra == '0;
    always_comb begin
      hit = 1'b0;
      bd = regs_q[ra];
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (BYPASS && wv[w] && write_addr[w*AW +: AW] == ra) begin
          hit = 1'b1;
          bd = write_data[w*XLEN +: XLEN];
        end
      end
    end
    assign read_data[p*XLEN +: XLEN] = zr ? '0 : bd;
    assign read_busy[p] = busy_q[ra] && !hit && !zr;
  end

  assign busy_vector = busy_q;
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed vector checks of default, no-bypass and dual-write register file builds
module tb_regfile_multiport;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logic a_we, a_re;
  logic [4:0] a_wa, a_rsa;
  logic [31:0] a_wd, a_bv;
  logic [9:0] a_ra;
  logic [63:0] a_rd;
  logic [1:0] a_rb;

  logic b_we, b_re;
  logic [4:0] b_wa, b_rsa;
  logic [31:0] b_wd, b_bv;
  logic [9:0] b_ra;
  logic [63:0] b_rd;
  logic [1:0] b_rb;

  logic [1:0] c_we;
  logic c_re;
  logic [9:0] c_wa;
  logic [4:0] c_rsa;
  logic [127:0] c_wd;
  logic [19:0] c_ra;
  logic [255:0] c_rd;
  logic [3:0] c_rb;
  logic [31:0] c_bv;

  regfile_multiport u0 (
    .clock(clk), .reset_n(rst_n), .read_addr(a_ra), .read_data(a_rd), .read_busy(a_rb),
    .write_enable(a_we), .write_addr(a_wa), .write_data(a_wd),
    .reserve_enable(a_re), .reserve_addr(a_rsa), .busy_vector(a_bv)
  );

  regfile_multiport #(.BYPASS(1'b0)) u1 (
    .clock(clk), .reset_n(rst_n), .read_addr(b_ra), .read_data(b_rd), .read_busy(b_rb),
    .write_enable(b_we), .write_addr(b_wa), .write_data(b_wd),
    .reserve_enable(b_re), .reserve_addr(b_rsa), .busy_vector(b_bv)
  );

  regfile_multiport #(.XLEN(64), .NUM_READ(4), .NUM_WRITE(2)) u2 (
    .clock(clk), .reset_n(rst_n), .read_addr(c_ra), .read_data(c_rd), .read_busy(c_rb),
    .write_enable(c_we), .write_addr(c_wa), .write_data(c_wd),
    .reserve_enable(c_re), .reserve_addr(c_rsa), .busy_vector(c_bv)
  );

  typedef struct {
    logic we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic re;
    logic [4:0] rsa;
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [1:0] rb;
    logic [31:0] bv;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Each row: inputs for one cycle, then outputs expected just before that cycle's edge
    tbl[0]  = '{1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd0, 32'h12345678, 32'h0, 2'b00, 32'h0};
    tbl[1]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd7, 5'd0, 32'h12345678, 32'h0, 2'b00, 32'h0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd9, 32'h0, 32'h0, 2'b00, 32'h0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd7, 32'h0, 32'h12345678, 2'b01, 32'h200};
    tbl[4]  = '{1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd9, 5'd9, 32'h55, 32'h55, 2'b00, 32'h200};
    tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3, 32'h55, 32'h0, 2'b00, 32'h0};
    tbl[6]  = '{1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd4, 5'd4, 5'd3, 32'h0, 32'hA5A5A5A5, 2'b00, 32'h0};
    tbl[7]  = '{1'b1, 5'd4, 32'h1, 1'b1, 5'd4, 5'd4, 5'd3, 32'h1, 32'hA5A5A5A5, 2'b00, 32'h10};
    tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0, 32'h1, 32'h0, 2'b01, 32'h10};
    tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd4, 32'h0, 32'h1, 2'b10, 32'h10};
    tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd4, 32'h0, 32'h1, 2'b10, 32'h10};
    tbl[11] = '{1'b1, 5'd4, 32'h2, 1'b1, 5'd2, 5'd4, 5'd2, 32'h2, 32'h0, 2'b00, 32'h10};
    tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd2, 32'h2, 32'h0, 2'b10, 32'h4};

    rst_n = 1'b0;
    {a_we, a_re, a_wa, a_rsa, a_wd, a_ra} = '0;
    {b_we, b_re, b_wa, b_rsa, b_wd, b_ra} = '0;
    {c_we, c_re, c_wa, c_rsa, c_wd, c_ra} = '0;
    a_ra = {5'd7, 5'd5};
    #3;
    chk("reset rd", a_rd, 64'h0);
    chk("reset rb", {62'h0, a_rb}, 64'h0);
    chk("reset bv", {32'h0, a_bv}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      a_we = tbl[i].we;
      a_wa = tbl[i].wa;
      a_wd = tbl[i].wd;
      a_re = tbl[i].re;
      a_rsa = tbl[i].rsa;
      a_ra = {tbl[i].ra1, tbl[i].ra0};
      #2;
      chk($sformatf("v%0d rd0", i), {32'h0, a_rd[31:0]}, {32'h0, tbl[i].rd0});
      chk($sformatf("v%0d rd1", i), {32'h0, a_rd[63:32]}, {32'h0, tbl[i].rd1});
      chk($sformatf("v%0d rb", i), {62'h0, a_rb}, {62'h0, tbl[i].rb});
      chk($sformatf("v%0d bv", i), {32'h0, a_bv}, {32'h0, tbl[i].bv});
    end

    @(negedge clk);
    {a_we, a_re} = '0;
    b_we = 1'b1; b_wa = 5'd3; b_wd = 32'hA5A5A5A5; b_ra = {5'd3, 5'd3};
    #2;
    chk("nobyp same cycle", {32'h0, b_rd[63:32]}, 64'h0);
    @(negedge clk);
    b_we = 1'b0; b_re = 1'b1; b_rsa = 5'd9;
    #2;
    chk("nobyp next cycle", {32'h0, b_rd[63:32]}, 64'hA5A5A5A5);
    @(negedge clk);
    b_re = 1'b0; b_we = 1'b1; b_wa = 5'd9; b_wd = 32'h55; b_ra = {5'd9, 5'd9};
    #2;
    chk("nobyp rb raw", {62'h0, b_rb}, 64'h3);
    chk("nobyp rd old", {32'h0, b_rd[31:0]}, 64'h0);
    @(negedge clk);
    b_we = 1'b0;
    #2;
    chk("nobyp bv clear", {32'h0, b_bv}, 64'h0);
    chk("nobyp rd new", {32'h0, b_rd[31:0]}, 64'h55);

    @(negedge clk);
    c_we = 2'b11; c_wa = {5'd10, 5'd10}; c_wd = {64'h2222, 64'h1111}; c_ra = {4{5'd10}};
    #2;
    for (int p = 0; p < 4; p++) chk($sformatf("dual byp p%0d", p), c_rd[p*64 +: 64], 64'h2222);
    @(negedge clk);
    c_we = 2'b00;
    #2;
    for (int p = 0; p < 4; p++) chk($sformatf("dual store p%0d", p), c_rd[p*64 +: 64], 64'h2222);
    @(negedge clk);
    c_we = 2'b11; c_wa = {5'd12, 5'd11}; c_wd = {64'hBBBB, 64'hAAAA}; c_ra = {5'd10, 5'd0, 5'd12, 5'd11};
    @(negedge clk);
    c_we = 2'b00;
    #2;
    chk("dual x11", c_rd[63:0], 64'hAAAA);
    chk("dual x12", c_rd[127:64], 64'hBBBB);
    chk("dual x0", c_rd[191:128], 64'h0);
    chk("dual x10", c_rd[255:192], 64'h2222);

    @(negedge clk);
    a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hDEADBEEF; a_ra = {5'd2, 5'd5};
    @(negedge clk);
    a_we = 1'b0;
    #1;
    chk("pre-reset x5", {32'h0, a_rd[31:0]}, 64'hDEADBEEF);
    chk("pre-reset bv", {32'h0, a_bv}, 64'h4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset x5", {32'h0, a_rd[31:0]}, 64'h0);
    chk("async reset bv", {32'h0, a_bv}, 64'h0);
    chk("async reset rb", {62'h0, a_rb}, 64'h0);
    chk("async reset dual", c_rd[255:192], 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
